// File: rtl/dac_link_pkg.sv
// Shared framing constants and receiver state encoding for the DAC serial link.
// The DAC transmitter and dac_serial_rx both import this package.
package dac_link_pkg;
  localparam int DAC_DATA_W    = 16;
  localparam int DAC_GUARD_LEN = 1;
  localparam int DAC_GAP_LEN   = 1;
  localparam int DAC_FRAME_LEN = DAC_DATA_W + DAC_GUARD_LEN + DAC_GAP_LEN;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_ARMED = 3'd1,
    RX_SHIFT = 3'd2,
    RX_GUARD = 3'd3,
    RX_TAIL  = 3'd4
  } dac_rx_state_e;
endpackage

// File: rtl/sat_counter.sv
// Up-counter that holds at MAX; synchronous clear and reset.
module sat_counter #(
  parameter int           W   = 16,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_value,
  output logic         o_at_max
);
  logic [W-1:0] r_value;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_value <= '0;
    end else if (i_clr) begin
      r_value <= '0;
    end else if (i_inc && (r_value != MAX)) begin
      r_value <= r_value + 1'b1;
    end
  end

  assign o_value  = r_value;
  assign o_at_max = (r_value == MAX);
endmodule

// File: rtl/dac_serial_rx.sv
// Deserialiser for the 18-clock DAC link: recovers MSB-first words, checks the
// sync/guard/gap framing, and reports lock and a saturating error count.
module dac_serial_rx
  import dac_link_pkg::*;
#(
  parameter int DATA_W      = DAC_DATA_W,
  parameter int LOCK_FRAMES = 4,
  parameter int ERR_CNT_W   = 16
) (
  input  logic                 DAC_clock,
  input  logic                 reset,
  input  logic                 DAC_word_sync,
  input  logic                 DAC_serial_data,
  output logic [DATA_W-1:0]    rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 locked
);
  localparam int                CNT_W    = $clog2(DATA_W);
  localparam int                GOOD_W   = $clog2(LOCK_FRAMES + 1);
  localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_FRAMES);

  dac_rx_state_e     r_state;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] r_rx_data;
  logic              r_rx_valid;
  logic              r_frame_err;

  logic              w_good;
  logic              w_err;
  logic              w_err_full;
  logic              w_good_full;
  logic [GOOD_W-1:0] w_good_cnt;

  // Frame outcome decided on the sampling clock; outputs follow one clock later.
  always_comb begin
    w_good = 1'b0;
    w_err  = 1'b0;
    case (r_state)
      RX_SHIFT: w_err  = !DAC_word_sync;
      RX_GUARD: begin
        w_good = DAC_word_sync && !DAC_serial_data;
        w_err  = !(DAC_word_sync && !DAC_serial_data);
      end
      RX_TAIL:  w_err  = DAC_word_sync;
      default: ;
    endcase
  end

  always_ff @(posedge DAC_clock) begin
    if (reset) begin
      r_state     <= RX_IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_valid  <= w_good;
      r_frame_err <= w_err;
      case (r_state)
        RX_IDLE: begin
          if (!DAC_word_sync) r_state <= RX_ARMED;
        end
        RX_ARMED: begin
          if (DAC_word_sync) begin
            r_shift   <= {r_shift[DATA_W-2:0], DAC_serial_data};
            r_bit_cnt <= CNT_W'(1);
            r_state   <= RX_SHIFT;
          end
        end
        RX_SHIFT: begin
          if (DAC_word_sync) begin
            r_shift <= {r_shift[DATA_W-2:0], DAC_serial_data};
            if (r_bit_cnt == CNT_W'(DATA_W - 1)) begin
              r_state <= RX_GUARD;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end else begin
            // Early sync drop doubles as the gap, so the next frame can follow at once.
            r_state <= RX_ARMED;
          end
        end
        RX_GUARD: begin
          if (w_good) begin
            r_rx_data <= r_shift;
            r_state   <= RX_TAIL;
          end else if (DAC_word_sync) begin
            r_state <= RX_IDLE;
          end else begin
            r_state <= RX_ARMED;
          end
        end
        RX_TAIL: begin
          r_state <= DAC_word_sync ? RX_IDLE : RX_ARMED;
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

  sat_counter #(
    .W   (ERR_CNT_W),
    .MAX ('1)
  ) u_err_cnt (
    .i_clk    (DAC_clock),
    .i_rst    (reset),
    .i_inc    (w_err && !w_err_full),
    .i_clr    (1'b0),
    .o_value  (err_count),
    .o_at_max (w_err_full)
  );

  sat_counter #(
    .W   (GOOD_W),
    .MAX (GOOD_MAX)
  ) u_good_cnt (
    .i_clk    (DAC_clock),
    .i_rst    (reset),
    .i_inc    (w_good && !w_good_full),
    .i_clr    (w_err),
    .o_value  (w_good_cnt),
    .o_at_max (w_good_full)
  );

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign locked    = (w_good_cnt == GOOD_MAX);
endmodule

// File: tb/tb_dac_serial_rx.sv
// Directed + randomized bench: a DAC transmitter model drives the link and a
// frame-level model predicts each frame's outcome and the status outputs.
module tb_dac_serial_rx;
  localparam int DW   = 16;
  localparam int LOCK = 4;
  localparam int EW   = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sync = 1'b0;
  logic          sdata = 1'b0;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          frame_err;
  logic [EW-1:0] err_count;
  logic          locked;

  always #5 clk = ~clk;

  dac_serial_rx #(
    .DATA_W      (DW),
    .LOCK_FRAMES (LOCK),
    .ERR_CNT_W   (EW)
  ) dut (
    .DAC_clock       (clk),
    .reset           (rst),
    .DAC_word_sync   (sync),
    .DAC_serial_data (sdata),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .frame_err       (frame_err),
    .err_count       (err_count),
    .locked          (locked)
  );

  int n_pass = 0;
  int n_total = 0;

  // Frame-level reference state
  logic [DW-1:0] exp_data = '0;
  int            exp_err  = 0;
  int            exp_good = 0;
  int            err_max  = (1 << EW) - 1;

  // Per-frame pulse observations
  int f_vcnt, f_ecnt, f_vat, f_eat, f_k;
  logic f_lock, f_both;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clr_track();
    f_vcnt = 0; f_ecnt = 0; f_vat = -1; f_eat = -1; f_k = 0;
    f_lock = 1'b0; f_both = 1'b0;
  endtask

  task automatic drive(input logic s, input logic d);
    @(negedge clk);
    sync  = s;
    sdata = d;
    @(posedge clk);
    #1;
    if (rx_valid) begin f_vcnt++; f_vat = f_k; f_lock = locked; end
    if (frame_err) begin f_ecnt++; f_eat = f_k; end
    if (rx_valid && frame_err) f_both = 1'b1;
    f_k++;
  endtask

  task automatic model_reset();
    exp_data = '0; exp_err = 0; exp_good = 0;
  endtask

  task automatic chk_status(input string tag);
    chk({tag, " rx_data"}, rx_data, exp_data);
    chk({tag, " err_count"}, err_count, exp_err);
    chk({tag, " locked"}, locked, exp_good == LOCK);
  endtask

  // One transmitted frame: nbits data bits (short if <16), guard bit, extra sync-high clocks, gap clocks.
  task automatic send(input string tag, input logic [DW-1:0] w, input int nbits,
                      input logic guard, input int extra_hi, input int gap);
    bit want_v, want_e;
    int e_at;
    clr_track();
    for (int i = 0; i < nbits; i++) drive(1'b1, w[DW-1-i]);
    if (nbits == DW) begin
      drive(1'b1, guard);
      for (int i = 0; i < extra_hi; i++) drive(1'b1, 1'b0);
    end
    for (int i = 0; i < gap; i++) drive(1'b0, 1'b0);
    want_v = (nbits == DW) && !guard;
    want_e = (nbits < DW) || guard || (extra_hi > 0);
    e_at   = (nbits < DW) ? nbits : (guard ? DW : DW + 1);
    chk({tag, " rx_valid pulses"}, f_vcnt, want_v);
    chk({tag, " frame_err pulses"}, f_ecnt, want_e);
    if (want_v) begin
      exp_data = w;
      if (exp_good < LOCK) exp_good++;
      chk({tag, " rx_valid clock"}, f_vat, DW);
      chk({tag, " locked at rx_valid"}, f_lock, exp_good == LOCK);
    end
    if (want_e) begin
      if (exp_err < err_max) exp_err++;
      exp_good = 0;
      chk({tag, " frame_err clock"}, f_eat, e_at);
    end
    chk({tag, " valid&err overlap"}, f_both, 1'b0);
    chk_status(tag);
  endtask

  initial begin
    logic [DW-1:0] w;
    int kind;

    // Reset state
    clr_track();
    repeat (3) drive(1'b0, 1'b0);
    chk("reset rx_valid", rx_valid, 1'b0);
    chk("reset frame_err", frame_err, 1'b0);
    chk_status("reset");
    rst = 1'b0;
    drive(1'b0, 1'b0);

    // 1: back-to-back good frames, lock on the 4th
    send("t1 A5C3", 16'hA5C3, DW, 1'b0, 0, 1);
    send("t1 0001", 16'h0001, DW, 1'b0, 0, 1);
    send("t1 f3", 16'(($urandom)), DW, 1'b0, 0, 1);
    send("t1 f4", 16'(($urandom)), DW, 1'b0, 0, 1);

    // 2: reset released while sync is high mid-frame
    w = 16'(($urandom));
    clr_track();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) drive(1'b1, w[DW-1-i]);
    rst = 1'b0;
    model_reset();
    clr_track();
    for (int i = 5; i < DW; i++) drive(1'b1, w[DW-1-i]);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    chk("t2 partial rx_valid", f_vcnt, 0);
    chk("t2 partial frame_err", f_ecnt, 0);
    chk_status("t2 partial");
    send("t2 first", 16'(($urandom)), DW, 1'b0, 0, 1);
    for (int i = 0; i < 3; i++) send("t2 lock", 16'(($urandom)), DW, 1'b0, 0, 1);

    // 3: short frame while locked, then recovery
    send("t3 short", 16'hBEEF, 8, 1'b0, 0, 1);
    send("t3 1234", 16'h1234, DW, 1'b0, 0, 1);

    // 4: guard bit error keeps previous word
    send("t4 guard", 16'hFFFF, DW, 1'b1, 0, 1);
    send("t4 next", 16'(($urandom)), DW, 1'b0, 0, 1);

    // 5: long frame
    send("t5 long", 16'h5A5A, DW, 1'b0, 2, 1);
    send("t5 next", 16'(($urandom)), DW, 1'b0, 0, 1);

    // Randomized mix of frame shapes and gap lengths
    for (int n = 0; n < 12; n++) begin
      kind = $urandom_range(0, 5);
      w = 16'(($urandom));
      case (kind)
        0: send("rnd short", w, $urandom_range(1, DW - 1), 1'b0, 0, $urandom_range(1, 3));
        1: send("rnd guard", w, DW, 1'b1, 0, $urandom_range(1, 3));
        2: send("rnd long", w, DW, 1'b0, $urandom_range(1, 3), $urandom_range(1, 3));
        default: send("rnd good", w, DW, 1'b0, 0, $urandom_range(1, 3));
      endcase
    end

    // 6: error counter saturation
    for (int n = 0; n < 20; n++)
      send("t6 short", 16'(($urandom)), $urandom_range(1, DW - 1), 1'b0, 0, 1);
    chk("t6 err_count saturated", err_count, err_max);
    send("t6 good", 16'hC0DE, DW, 1'b0, 0, 1);

    // Reset mid-frame clears all outputs on the next clock
    w = 16'(($urandom));
    clr_track();
    for (int i = 0; i < 7; i++) drive(1'b1, w[DW-1-i]);
    rst = 1'b1;
    drive(1'b1, w[DW-1-7]);
    model_reset();
    chk("t6 rst rx_valid", rx_valid, 1'b0);
    chk("t6 rst frame_err", frame_err, 1'b0);
    chk_status("t6 rst");
    rst = 1'b0;
    clr_track();
    for (int i = 8; i < DW; i++) drive(1'b1, w[DW-1-i]);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    chk("t6 post-rst rx_valid", f_vcnt, 0);
    chk("t6 post-rst frame_err", f_ecnt, 0);
    send("t6 recover", 16'(($urandom)), DW, 1'b0, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
